// File: rtl/mont_exp_pkg.sv
// Shared constants, state encoding and helpers for the Montgomery
// exponentiator host front end.
//
// OP_W         : operand / result width (bits)
// WORD_W       : stream word width (bits); OP_W is a multiple of it
// EXP_W        : exponent width (bits); EXP_W <= WORD_W
// WORDS_PER_OP : stream words per operand
// LOAD_OPS     : number of full-width operands in a job (msg, n, rmodn, r2modn)
package mont_exp_pkg;

    localparam int OP_W         = 1024;
    localparam int WORD_W       = 32;
    localparam int EXP_W        = 16;
    localparam int WORDS_PER_OP = OP_W / WORD_W;
    localparam int LOAD_OPS     = 4;

    localparam int CNT_W = $clog2(WORDS_PER_OP);
    localparam int IDX_W = $clog2(LOAD_OPS + 1);

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_OP - 1);
    // Operand index that selects the single trailing exponent word.
    localparam logic [IDX_W-1:0] EXP_IDX   = IDX_W'(LOAD_OPS);

    typedef enum logic [2:0] {
        LOAD,
        CLR,
        START,
        WAIT,
        UNLOAD
    } state_t;

    // Bit position of word k inside an operand register.
    function automatic int word_lsb(input logic [CNT_W-1:0] k);
        return 32'(k) * WORD_W;
    endfunction

endpackage

// File: rtl/mont_word_serializer.sv
// Parallel-load shift register that streams an OP_W-bit value out as
// WORDS_PER_OP words, least significant word first.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture load_data and start streaming (word 0 first)
//   load_data   : OP_W-bit value to stream
//   out_valid   : a word is presented on out_data
//   out_ready   : sink accepts the presented word
//   out_data    : current word (low word of the shift register)
//   out_last    : high with the final word of the value
module mont_word_serializer
    import mont_exp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [OP_W-1:0]   load_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last
);

    logic [OP_W-1:0]  shreg;
    logic [CNT_W-1:0] word_cnt;
    logic             fire;

    assign fire = out_valid && out_ready;

    // load and fire are never simultaneous in the host interface (capture
    // only happens while nothing is being streamed), so load simply wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            word_cnt  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            shreg     <= load_data;
            word_cnt  <= '0;
            out_valid <= 1'b1;
        end else if (fire) begin
            shreg <= shreg >> WORD_W;
            if (word_cnt == LAST_WORD) begin
                word_cnt  <= '0;
                out_valid <= 1'b0;
            end else begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

    // Both outputs come straight from registers, so they hold still while
    // the sink stalls.
    assign out_data = shreg[WORD_W-1:0];
    assign out_last = out_valid && (word_cnt == LAST_WORD);

endmodule

// File: rtl/mont_exp_host_if.sv
// Host-side front end for montgomery_exp. Assembles one exponentiation
// job from a 32-bit word stream (msg, n, rmodn, r2modn LSW first, then one
// exponent word), sequences the core's reset and start pins, waits for
// core_done and streams the OP_W-bit result back as 32 words.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : input word handshake, in_data carries the word
//   out_valid/out_ready   : result word handshake, out_data carries the word
//   out_last              : marks the final result word
//   busy                  : first accepted word .. last result word accepted
//   core_resetn           : active-low reset pulse to the core before start
//   core_start            : one-cycle start pulse to the core
//   core_msg/n/rmodn/r2modn, core_exp : operand registers driving the core
//   core_result, core_done: core outputs
module mont_exp_host_if
    import mont_exp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,

    output logic              busy,

    output logic              core_resetn,
    output logic              core_start,
    output logic [OP_W-1:0]   core_msg,
    output logic [OP_W-1:0]   core_n,
    output logic [OP_W-1:0]   core_rmodn,
    output logic [OP_W-1:0]   core_r2modn,
    output logic [EXP_W-1:0]  core_exp,
    input  logic [OP_W-1:0]   core_result,
    input  logic              core_done
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] word_cnt;
    logic [IDX_W-1:0] op_idx;

    logic in_fire;
    logic out_fire;
    logic capture;
    logic we_msg;
    logic we_n;
    logic we_rmodn;
    logic we_r2modn;
    logic we_exp;

    assign in_ready = (state == LOAD) && !reset;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // core_done is only meaningful once the core has been started; any
    // level left over from a previous run is ignored in CLR and START.
    assign capture = (state == WAIT) && core_done;

    // Per-operand word enables: each operand register only moves on its
    // own handshakes.
    assign we_msg    = in_fire && (op_idx == IDX_W'(0));
    assign we_n      = in_fire && (op_idx == IDX_W'(1));
    assign we_rmodn  = in_fire && (op_idx == IDX_W'(2));
    assign we_r2modn = in_fire && (op_idx == IDX_W'(3));
    assign we_exp    = in_fire && (op_idx == EXP_IDX);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD:    if (we_exp)               state_nxt = CLR;
            CLR:                               state_nxt = START;
            START:                             state_nxt = WAIT;
            WAIT:    if (capture)              state_nxt = UNLOAD;
            UNLOAD:  if (out_fire && out_last) state_nxt = LOAD;
            default:                           state_nxt = LOAD;
        endcase
    end

    assign core_resetn = !reset && (state != CLR);
    assign core_start  = !reset && (state == START);

    // ---------------- load counters ----------------
    // word_cnt walks the 32 words of an operand, op_idx picks the operand;
    // index EXP_IDX takes exactly one word and then both wrap for the next job.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt <= '0;
            op_idx   <= '0;
        end else if (in_fire) begin
            if (we_exp) begin
                word_cnt <= '0;
                op_idx   <= '0;
            end else if (word_cnt == LAST_WORD) begin
                word_cnt <= '0;
                op_idx   <= op_idx + IDX_W'(1);
            end else begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

    // ---------------- operand registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            core_msg <= '0;
        end else if (we_msg) begin
            core_msg[word_lsb(word_cnt) +: WORD_W] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_n <= '0;
        end else if (we_n) begin
            core_n[word_lsb(word_cnt) +: WORD_W] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_rmodn <= '0;
        end else if (we_rmodn) begin
            core_rmodn[word_lsb(word_cnt) +: WORD_W] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_r2modn <= '0;
        end else if (we_r2modn) begin
            core_r2modn[word_lsb(word_cnt) +: WORD_W] <= in_data;
        end
    end

    // Only the low EXP_W bits of the exponent word are kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_exp <= '0;
        end else if (we_exp) begin
            core_exp <= in_data[EXP_W-1:0];
        end
    end

    // ---------------- busy flag ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
        end else if (in_fire) begin
            busy <= 1'b1;
        end else if (out_fire && out_last) begin
            busy <= 1'b0;
        end
    end

    // ---------------- result streaming ----------------
    mont_word_serializer u_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (capture),
        .load_data (core_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_mont_exp_host_if.sv
module tb_mont_exp_host_if;
    import mont_exp_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              core_resetn;
    logic              core_start;
    logic [OP_W-1:0]   core_msg;
    logic [OP_W-1:0]   core_n;
    logic [OP_W-1:0]   core_rmodn;
    logic [OP_W-1:0]   core_r2modn;
    logic [EXP_W-1:0]  core_exp;
    logic [OP_W-1:0]   core_result = '0;
    logic              core_done   = 1'b0;

    always #5 clk = ~clk;

    mont_exp_host_if dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .core_resetn (core_resetn),
        .core_start  (core_start),
        .core_msg    (core_msg),
        .core_n      (core_n),
        .core_rmodn  (core_rmodn),
        .core_r2modn (core_r2modn),
        .core_exp    (core_exp),
        .core_result (core_result),
        .core_done   (core_done)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural core stub: done pulses stub_n cycles after the start
    // cycle. core_result carries junk except while done is legitimately high.
    localparam logic [OP_W-1:0] JUNK = {32{32'hDEAD_BEEF}};
    int              stub_n        = 50;
    bit              stub_spurious = 1'b0;
    bit              stub_run      = 1'b0;
    int              stub_cnt      = 0;
    logic [OP_W-1:0] stub_result   = '0;

    always begin
        @(posedge clk);
        #2;
        if (core_start) begin
            stub_run    = 1'b1;
            stub_cnt    = 0;
            core_done   = stub_spurious;
            core_result = JUNK;
        end else if (stub_spurious && !core_resetn) begin
            core_done   = 1'b1;
            core_result = JUNK;
        end else if (stub_run) begin
            stub_cnt++;
            if (stub_cnt == stub_n) begin
                core_done   = 1'b1;
                core_result = stub_result;
                stub_run    = 1'b0;
            end else begin
                core_done   = 1'b0;
                core_result = JUNK;
            end
        end else begin
            core_done   = 1'b0;
            core_result = JUNK;
        end
    end

    // Reference model state
    logic [31:0]     job [129];
    logic [OP_W-1:0] m_msg, m_n, m_rmodn, m_r2modn;
    logic [15:0]     m_exp;
    logic [31:0]     exp_words [32];

    task automatic model_job();
        m_msg = '0; m_n = '0; m_rmodn = '0; m_r2modn = '0;
        for (int i = 0; i < 128; i++) begin
            logic [OP_W-1:0] w;
            w = OP_W'(job[i]) << (32 * (i % 32));
            case (i / 32)
                0:       m_msg    |= w;
                1:       m_n      |= w;
                2:       m_rmodn  |= w;
                default: m_r2modn |= w;
            endcase
        end
        m_exp = job[128][15:0];
    endtask

    task automatic set_result(input logic [OP_W-1:0] res);
        stub_result = res;
        for (int k = 0; k < 32; k++) exp_words[k] = 32'(res >> (32 * k));
    endtask

    task automatic random_op(output logic [OP_W-1:0] r);
        for (int k = 0; k < 32; k++) r[32*k +: 32] = $urandom();
    endtask

    task automatic mapping_job();
        for (int i = 0; i < 128; i++) job[i] = 32'h1000_0000 + i;
        job[128] = 32'hFFFF_B5DF;
        model_job();
    endtask

    task automatic random_job();
        for (int i = 0; i < 129; i++) job[i] = $urandom();
        model_job();
    endtask

    // Entered just after a negedge; returns just after the negedge that
    // follows the edge carrying the transfer.
    task automatic send_word(input logic [31:0] w);
        int guard = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            errors++;
            $display("FAIL send_word timeout: in_ready got 0 required 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_job(input int n_words, input bit gaps);
        for (int i = 0; i < n_words; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_word(job[i]);
        end
    endtask

    // mode 0: out_ready held high, 1: toggles every cycle, 2: random
    task automatic collect(input int mode, input string tag, output int cycles);
        int          got = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        while (got < 32 && cyc < 3000) begin
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = (cyc % 2 == 0);
            else                out_ready = 1'($urandom_range(0, 1));
            if (out_valid) begin
                if (stalled) begin
                    checks++;
                    if (out_data !== prev_data || out_last !== prev_last) begin
                        errors++;
                        $display("FAIL %s stall_stable word %0d: got %h/%b required %h/%b",
                                 tag, got, out_data, out_last, prev_data, prev_last);
                    end
                end
                if (out_ready) begin
                    checks++;
                    if (out_data !== exp_words[got]) begin
                        errors++;
                        $display("FAIL %s word %0d data: got %h required %h",
                                 tag, got, out_data, exp_words[got]);
                    end
                    checks++;
                    if (out_last !== (got == 31)) begin
                        errors++;
                        $display("FAIL %s word %0d out_last: got %b required %b",
                                 tag, got, out_last, (got == 31));
                    end
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    prev_data = out_data;
                    prev_last = out_last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        cycles = cyc;
        checks++;
        if (got != 32) begin
            errors++;
            $display("FAIL %s timeout: words got %0d required 32", tag, got);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s extra_word: out_valid got %b required 0", tag, out_valid);
        end
    endtask

    task automatic wait_out_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, core_resetn, out_valid, out_last, core_start, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {in_ready, core_resetn, out_valid, out_last, core_start, busy});
        end
        checks++;
        if ({core_msg, core_n, core_rmodn, core_r2modn, core_exp, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got exp=%h msg0=%h out=%h required 0",
                     core_exp, core_msg[31:0], out_data);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || core_resetn !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready/core_resetn/busy got %b%b%b required 110",
                     in_ready, core_resetn, busy);
        end
    endtask

    task automatic check_mapping(input string tag);
        checks++;
        if (core_msg[31:0] !== 32'h1000_0000 || core_msg[1023:992] !== 32'h1000_001F) begin
            errors++;
            $display("FAIL %s msg_ends: got %h/%h required 10000000/1000001f",
                     tag, core_msg[31:0], core_msg[1023:992]);
        end
        checks++;
        if (core_n[31:0] !== 32'h1000_0020) begin
            errors++;
            $display("FAIL %s n_word0: got %h required 10000020", tag, core_n[31:0]);
        end
        checks++;
        if (core_r2modn[1023:992] !== 32'h1000_007F) begin
            errors++;
            $display("FAIL %s r2modn_top: got %h required 1000007f", tag, core_r2modn[1023:992]);
        end
        checks++;
        if (core_exp !== 16'hB5DF) begin
            errors++;
            $display("FAIL %s exp: got %h required b5df", tag, core_exp);
        end
    endtask

    task automatic check_operands(input string tag);
        checks++;
        if (core_msg !== m_msg || core_n !== m_n || core_rmodn !== m_rmodn ||
            core_r2modn !== m_r2modn || core_exp !== m_exp) begin
            errors++;
            $display("FAIL %s operands: got msg0=%h n0=%h rm0=%h r2m0=%h exp=%h required %h %h %h %h %h",
                     tag, core_msg[31:0], core_n[31:0], core_rmodn[31:0], core_r2modn[31:0],
                     core_exp, m_msg[31:0], m_n[31:0], m_rmodn[31:0], m_r2modn[31:0], m_exp);
        end
    endtask

    task automatic test_load_mapping();
        logic [OP_W-1:0] res;
        mapping_job();
        res = '0;
        for (int k = 0; k < 32; k++) res |= OP_W'(32'hA5A5_0000 + k) << (32 * k);
        set_result(res);
        stub_n = 50;
        send_word(job[0]);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_first: got %b required 1", busy);
        end
        for (int i = 1; i < 129; i++) send_word(job[i]);
        check_mapping("load_mapping");
        check_operands("load_mapping");
    endtask

    // Runs from the negedge right after the 129th transfer.
    task automatic test_start_sequencing();
        checks++;
        if ({core_resetn, core_start, in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL seq_clr: resetn/start/in_ready got %b required 000",
                     {core_resetn, core_start, in_ready});
        end
        @(negedge clk);
        checks++;
        if ({core_resetn, core_start, in_ready} !== 3'b110) begin
            errors++;
            $display("FAIL seq_start: resetn/start/in_ready got %b required 110",
                     {core_resetn, core_start, in_ready});
        end
        @(negedge clk);
        checks++;
        if ({core_resetn, core_start, in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL seq_wait: resetn/start/in_ready got %b required 100",
                     {core_resetn, core_start, in_ready});
        end
        check_operands("seq_hold");
    endtask

    task automatic test_unload_order();
        int g = 0;
        int cycles;
        while (!core_done && g < 500) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (g >= 500 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_wait: waited %0d out_valid %b in_ready %b required <500 0 0",
                     g, out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_words[0]) begin
            errors++;
            $display("FAIL done_latency: out_valid/data got %b/%h required 1/%h",
                     out_valid, out_data, exp_words[0]);
        end
        collect(0, "unload_order", cycles);
        checks++;
        if (cycles != 32) begin
            errors++;
            $display("FAIL unload_cycles: got %0d required 32", cycles);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL unload_end: in_ready/busy got %b%b required 10", in_ready, busy);
        end
        check_mapping("after_unload");
    endtask

    task automatic test_backpressure(input string tag);
        logic [OP_W-1:0] res;
        int cycles;
        random_job();
        random_op(res);
        set_result(res);
        stub_n = $urandom_range(5, 30);
        send_job(129, 1'b1);
        check_operands(tag);
        collect(1, tag, cycles);
        check_operands(tag);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_end: got %b required 1", tag, in_ready);
        end
    endtask

    task automatic test_mid_load_reset();
        logic [OP_W-1:0] res;
        int cycles;
        mapping_job();
        random_op(res);
        set_result(res);
        stub_n = 12;
        send_job(40, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, core_resetn, out_valid, out_last, core_start, busy} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_ctrl: got %b required 000000",
                     {in_ready, core_resetn, out_valid, out_last, core_start, busy});
        end
        checks++;
        if ({core_msg, core_n, core_rmodn, core_r2modn, core_exp, out_data} !== '0) begin
            errors++;
            $display("FAIL midreset_data: got msg0=%h n0=%h required 0", core_msg[31:0], core_n[31:0]);
        end
        reset = 1'b0;
        @(negedge clk);
        send_job(129, 1'b1);
        check_mapping("reload");
        check_operands("reload");
        collect(2, "reload_unload", cycles);
    endtask

    task automatic test_spurious_done();
        logic [OP_W-1:0] res;
        int cyc;
        int cycles;
        random_job();
        random_op(res);
        set_result(res);
        stub_n = 20;
        stub_spurious = 1'b1;
        send_job(129, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL spurious_clr: out_valid got %b required 0", out_valid);
        end
        wait_out_valid(cyc);
        // CLR negedge -> START (1) -> 20 stub cycles in WAIT -> capture edge
        checks++;
        if (cyc != stub_n + 2) begin
            errors++;
            $display("FAIL spurious_capture_time: got %0d cycles required %0d", cyc, stub_n + 2);
        end
        collect(0, "spurious", cycles);
        stub_spurious = 1'b0;
        check_operands("spurious");
    endtask

    initial begin
        test_reset();
        test_load_mapping();
        test_start_sequencing();
        test_unload_order();
        test_backpressure("backpressure_a");
        test_backpressure("backpressure_b");
        test_mid_load_reset();
        test_spurious_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
